mem_access_unit: RTL

//  Sits between the multi-cycle datapath/control FSM and the byte-addressed, word-wide data memory (mem_rd/mem_wr/addr/W_data/R_data).

---
 rtl/mem_access_unit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: one load or store per request between the control FSM and a
// byte-addressed, word-wide data memory. Checks size/alignment/range, extracts
// little-endian lanes with sign/zero extension for loads and performs
// read-modify-write for sub-word stores. Completion is a one-cycle done pulse.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req, we, size,      request handshake and access attributes
//   sign_ext, addr,
//   wdata
//   ready, done, err    IDLE indicator, completion pulse, error flag with done
//   rdata               load result, held between successful loads
//   mem_rd, mem_wr,     memory-side read/write enables, word-aligned address
//   mem_addr, mem_wdata and full write word
//   mem_rdata           memory read data (combinational from mem_addr)
module mem_access_unit #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned RD_CYCLES = 1,
   parameter int unsigned WR_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CW = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [1:0]      size_q, size_d;
   logic            sext_q, sext_d;
   logic [1:0]      off_q, off_d;
   logic [15:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [31:0]     mem_addr_q, mem_addr_d;
   logic [31:0]     mem_wdata_q, mem_wdata_d;
   logic            bad_req_c;

   // Little-endian lane select with optional sign extension
   function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] off, input logic sx);
      logic [31:0] sh;
      sh = w >> {off, 3'b000};
      case (sz)
         2'b00:   return {{24{sx & sh[7]}}, sh[7:0]};
         2'b01:   return {{16{sx & sh[15]}}, sh[15:0]};
         default: return w;
      endcase
   endfunction

   // Replace the addressed byte/half of the buffered word with store data
   function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [15:0] d,
                                              input logic [1:0] sz, input logic [1:0] off);
      logic [31:0] mask;
      logic [31:0] ins;
      case (sz)
         2'b00: begin
            mask = 32'h0000_00FF << {off, 3'b000};
            ins  = {24'd0, d[7:0]} << {off, 3'b000};
         end
         2'b01: begin
            mask = 32'h0000_FFFF << {off, 3'b000};
            ins  = {16'd0, d} << {off, 3'b000};
         end
         default: begin
            mask = '1;
            ins  = {16'd0, d};
         end
      endcase
      return (w & ~mask) | ins;
   endfunction

   // Request legality: illegal size, misalignment, or access running past memory end
   always_comb begin
      bad_req_c = 1'b0;
      case (size)
         2'b00:   bad_req_c = (addr > 32'(MEM_BYTES - 1));
         2'b01:   bad_req_c = addr[0] | (addr > 32'(MEM_BYTES - 2));
         2'b10:   bad_req_c = (addr[1:0] != 2'b00) | (addr > 32'(MEM_BYTES - 4));
         default: bad_req_c = 1'b1;
      endcase
   end

   // Next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      size_d      = size_q;
      sext_d      = sext_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d    = we;
               size_d  = size;
               sext_d  = sign_ext;
               off_d   = addr[1:0];
               wdata_d = wdata[15:0];
               cnt_d   = '0;
               if (bad_req_c) begin
                  state_d = S_ERR;
               end else begin
                  mem_addr_d = {addr[31:2], 2'b00};
                  if (we && (size == 2'b10)) begin
                     mem_wdata_d = wdata;
                     state_d     = S_WRITE;
                  end else begin
                     state_d = S_READ;
                  end
               end
            end
         end

         S_READ: begin
            // mem_rdata on the last read cycle is the word buffer
            if (cnt_q == CW'(RD_CYCLES - 1)) begin
               cnt_d = '0;
               if (we_q) begin
                  mem_wdata_d = lane_merge(mem_rdata, wdata_q, size_q, off_q);
                  state_d     = S_WRITE;
               end else begin
                  rdata_d = lane_extract(mem_rdata, size_q, off_q, sext_q);
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_WRITE: begin
            if (cnt_q == CW'(WR_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         sext_q      <= 1'b0;
         off_q       <= 2'b00;
         wdata_q     <= '0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         size_q      <= size_d;
         sext_q      <= sext_d;
         off_q       <= off_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // State-decoded handshake and memory strobes; READ/WRITE are exclusive
   assign ready     = (state_q == S_IDLE);
   assign done      = (state_q == S_DONE) || (state_q == S_ERR);
   assign err       = (state_q == S_ERR);
   assign mem_rd    = (state_q == S_READ);
   assign mem_wr    = (state_q == S_WRITE);
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
